// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus bundle for instr_fetch_queue: PC handshake, instruction
// memory request/response, redirect, and the decode-facing queue head.
// slave is the fetch queue's view; master is the environment driving it.
interface instr_fetch_queue_if;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fault;

    modport slave (
        input  pc_in, imem_ack, imem_rdata, flush, inst_ready,
        output pc_advance, imem_req, imem_addr, inst_valid, inst_out,
               inst_pc, fault
    );

    modport master (
        output pc_in, imem_ack, imem_rdata, flush, inst_ready,
        input  pc_advance, imem_req, imem_addr, inst_valid, inst_out,
               inst_pc, fault
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: single-outstanding instruction fetcher feeding a
// 2-entry {instruction, pc} queue towards decode.
// A fetch takes two cycles at best: IDLE latches the word-aligned PC, REQ
// holds the request until the memory acks. A flush empties the queue and
// turns an in-flight request into DROP so its data is thrown away.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned PCs in
// a FAULT state instead of silently aligning them.
module instr_fetch_queue (
    input  logic              clock,
    input  logic              reset,
    instr_fetch_queue_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
`ifdef FETCH_ALIGN_CHECK_EN
        , FAULT
`endif
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_addr;
    logic [1:0]  r_count;
    logic [31:0] r_instr [2];
    logic [31:0] r_pcq   [2];

    logic        w_loadAddr;
    logic        w_push;
    logic        w_pop;
    logic        w_accept;
    logic        w_wrIdx;
    logic        w_req;
    logic        w_fault;

    // Next-state and control decode for the fetch sequencer
    always_comb begin
        w_nextState = r_state;
        w_loadAddr  = 1'b0;
        w_push      = 1'b0;
        w_req       = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.flush && r_count != 2'd2) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (bus.pc_in[1:0] != 2'b00) begin
                        w_nextState = FAULT;
                    end else begin
                        w_loadAddr  = 1'b1;
                        w_nextState = REQ;
                    end
`else
                    w_loadAddr  = 1'b1;
                    w_nextState = REQ;
`endif
                end
            end
            REQ: begin
                w_req = 1'b1;
                if (bus.imem_ack) begin
                    w_push      = !bus.flush;
                    w_nextState = IDLE;
                end else if (bus.flush) begin
                    w_nextState = DROP;
                end
            end
            DROP: begin
                w_req = 1'b1;
                if (bus.imem_ack) begin
                    w_nextState = IDLE;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: begin
                w_fault = 1'b1;
                if (bus.flush) begin
                    w_nextState = IDLE;
                end
            end
`endif
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Sequencer state and the request address, held for the whole request
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= 32'd0;
        end else begin
            r_state <= w_nextState;
            if (w_loadAddr) begin
                r_addr <= bus.pc_in & 32'hFFFF_FFFC;
            end
        end
    end

    assign w_pop    = (r_count != 2'd0) && bus.inst_ready;
    assign w_accept = w_push && (w_pop || r_count != 2'd2);
    assign w_wrIdx  = (r_count == 2'd2) || (r_count == 2'd1 && !w_pop);

    // Shift-register queue: entry 0 is always the head; flush wins over push/pop
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_instr[0] <= 32'd0;
            r_instr[1] <= 32'd0;
            r_pcq[0]   <= 32'd0;
            r_pcq[1]   <= 32'd0;
        end else if (bus.flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_instr[0] <= r_instr[1];
                r_pcq[0]   <= r_pcq[1];
            end
            if (w_accept) begin
                r_instr[w_wrIdx] <= bus.imem_rdata;
                r_pcq[w_wrIdx]   <= r_addr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.pc_advance = w_push;
    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_addr;
    assign bus.inst_valid = (r_count != 2'd0);
    assign bus.inst_out   = (r_count != 2'd0) ? r_instr[0] : 32'd0;
    assign bus.inst_pc    = (r_count != 2'd0) ? r_pcq[0]   : 32'd0;
    assign bus.fault      = w_fault;

endmodule
